move_sequencer: RTL and testbench

//  Turn/commit controller between the user input FSM and build_board. Accepts one move request
//  (from,to) per turn, drives moveData to checkAllow, waits a fixed settle window, then sequences
//  the board writes (destination, then source) over changePiece. Toggles turn, counts moves,

---
 rtl/chess_pkg.sv | 37 +++
 rtl/move_precheck.sv | 29 ++
 rtl/move_sequencer.sv | 173 +++++++++++++++++
 tb/tb_move_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess encodings: piece codes, bus field offsets and sequencer state encoding.
package chess_pkg;

  localparam int SQ_W       = 6;
  localparam int PIECE_W    = 4;
  localparam int COLOUR_BIT = 3;

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  // moveData = {turn, from, to, chk_req}
  localparam int MD_CHK  = 0;
  localparam int MD_TO   = 1;
  localparam int MD_FROM = 7;
  localparam int MD_TURN = 13;

  // changePiece = {we, square, piece}
  localparam int CP_PIECE = 0;
  localparam int CP_SQ    = 4;
  localparam int CP_WE    = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_WR_DST = 3'd2,
    S_WR_SRC = 3'd3,
    S_COMMIT = 3'd4,
    S_REJECT = 3'd5,
    S_OVER   = 3'd6
  } state_t;

endpackage

// File: rtl/move_precheck.sv
// Cheap legality screen done at accept time, plus promotion and king-capture flags.
module move_precheck
  import chess_pkg::*;
(
  input  logic [5:0] sq_from,
  input  logic [5:0] sq_to,
  input  logic [3:0] src,
  input  logic [3:0] dst,
  input  logic       turn,
  output logic       ok,
  output logic       promote,
  output logic       king_cap
);

  logic src_empty;
  logic dst_empty;

  assign src_empty = (src[2:0] == EMPTY);
  assign dst_empty = (dst[2:0] == EMPTY);

  assign ok = (sq_from != sq_to) && !src_empty && (src[COLOUR_BIT] == turn) &&
              (dst_empty || (dst[COLOUR_BIT] != turn));

  // white promotes on rank 7, black on rank 0
  assign promote  = (src[2:0] == PAWN) &&
                    (src[COLOUR_BIT] ? (sq_to[5:3] == 3'd0) : (sq_to[5:3] == 3'd7));
  assign king_cap = (dst[2:0] == KING);

endmodule

// File: rtl/move_sequencer.sv
// Turn/commit controller: screens a move, asks checkAllow, then writes dst and src squares.
//
// state    | meaning
// IDLE     | ready for a request, move_ready high
// CHECK    | moveData presented with chk_req for CHECK_LAT cycles
// WR_DST   | destination square written (promotion applied)
// WR_SRC   | source square cleared
// COMMIT   | move_done pulse, count and turn advance
// REJECT   | move_reject pulse
// OVER     | king captured, locked until reset
module move_sequencer
  import chess_pkg::*;
#(
  parameter int         CHECK_LAT  = 4,
  parameter int         MOVE_CNT_W = 10,
  parameter logic [2:0] PROMO_TYPE = 3'd5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [255:0]          board_in,
  input  logic                  move_valid,
  input  logic [5:0]            move_from,
  input  logic [5:0]            move_to,
  output logic                  move_ready,
  input  logic                  allowMove,
  output logic [13:0]           moveData,
  output logic [10:0]           changePiece,
  output logic                  move_done,
  output logic                  move_reject,
  output logic [MOVE_CNT_W-1:0] move_count,
  output logic                  game_over
);

  localparam int                TMR_W    = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(CHECK_LAT - 1);

  state_t              state;
  logic                turn;
  logic [SQ_W-1:0]     from_q;
  logic [SQ_W-1:0]     to_q;
  logic [PIECE_W-1:0]  src_q;
  logic                promote_q;
  logic                king_cap_q;
  logic [TMR_W-1:0]    tmr;
  logic                chk_req;
  logic                we_q;
  logic [SQ_W-1:0]     sq_q;
  logic [PIECE_W-1:0]  piece_q;

  logic [PIECE_W-1:0]  src_live;
  logic [PIECE_W-1:0]  dst_live;
  logic                pre_ok;
  logic                pre_promote;
  logic                pre_king_cap;

  assign src_live = board_in[{move_from, 2'b00} +: PIECE_W];
  assign dst_live = board_in[{move_to, 2'b00} +: PIECE_W];

  move_precheck u_precheck (
    .sq_from  (move_from),
    .sq_to    (move_to),
    .src      (src_live),
    .dst      (dst_live),
    .turn     (turn),
    .ok       (pre_ok),
    .promote  (pre_promote),
    .king_cap (pre_king_cap)
  );

  assign moveData[MD_TURN]           = turn;
  assign moveData[MD_FROM +: SQ_W]   = from_q;
  assign moveData[MD_TO +: SQ_W]     = to_q;
  assign moveData[MD_CHK]            = chk_req;

  assign changePiece[CP_WE]             = we_q;
  assign changePiece[CP_SQ +: SQ_W]     = sq_q;
  assign changePiece[CP_PIECE +: PIECE_W] = piece_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      turn        <= 1'b0;
      from_q      <= '0;
      to_q        <= '0;
      src_q       <= '0;
      promote_q   <= 1'b0;
      king_cap_q  <= 1'b0;
      tmr         <= '0;
      chk_req     <= 1'b0;
      we_q        <= 1'b0;
      sq_q        <= '0;
      piece_q     <= '0;
      move_ready  <= 1'b1;
      move_done   <= 1'b0;
      move_reject <= 1'b0;
      move_count  <= '0;
      game_over   <= 1'b0;
    end else begin
      move_done   <= 1'b0;
      move_reject <= 1'b0;
      chk_req     <= 1'b0;
      we_q        <= 1'b0;
      sq_q        <= '0;
      piece_q     <= '0;
      case (state)
        S_IDLE: begin
          if (move_valid) begin
            from_q     <= move_from;
            to_q       <= move_to;
            src_q      <= src_live;
            promote_q  <= pre_promote;
            king_cap_q <= pre_king_cap;
            move_ready <= 1'b0;
            if (pre_ok) begin
              state   <= S_CHECK;
              chk_req <= 1'b1;
              tmr     <= TMR_LOAD;
            end else begin
              state       <= S_REJECT;
              move_reject <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (tmr == '0) begin
            if (allowMove) begin
              state   <= S_WR_DST;
              we_q    <= 1'b1;
              sq_q    <= to_q;
              piece_q <= promote_q ? {src_q[COLOUR_BIT], PROMO_TYPE} : src_q;
            end else begin
              state       <= S_REJECT;
              move_reject <= 1'b1;
            end
          end else begin
            tmr     <= tmr - TMR_W'(1);
            chk_req <= 1'b1;
          end
        end
        S_WR_DST: begin
          state <= S_WR_SRC;
          we_q  <= 1'b1;
          sq_q  <= from_q;
        end
        S_WR_SRC: begin
          state      <= S_COMMIT;
          move_done  <= 1'b1;
          move_count <= move_count + MOVE_CNT_W'(1);
          turn       <= ~turn;
          if (king_cap_q) game_over <= 1'b1;
        end
        S_COMMIT: begin
          if (king_cap_q) begin
            state <= S_OVER;
          end else begin
            state      <= S_IDLE;
            move_ready <= 1'b1;
          end
        end
        S_REJECT: begin
          state      <= S_IDLE;
          move_ready <= 1'b1;
        end
        S_OVER: state <= S_OVER;
        default: begin
          state      <= S_IDLE;
          move_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: stimulus queues expectations, a negedge monitor checks them.
module tb_move_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] board;
  logic         move_valid;
  logic [5:0]   move_from;
  logic [5:0]   move_to;
  logic         move_ready;
  logic         allowMove;
  logic [13:0]  moveData;
  logic [10:0]  changePiece;
  logic         move_done;
  logic         move_reject;
  logic [9:0]   move_count;
  logic         game_over;

  always #5 clk = ~clk;

  move_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .board_in    (board),
    .move_valid  (move_valid),
    .move_from   (move_from),
    .move_to     (move_to),
    .move_ready  (move_ready),
    .allowMove   (allowMove),
    .moveData    (moveData),
    .changePiece (changePiece),
    .move_done   (move_done),
    .move_reject (move_reject),
    .move_count  (move_count),
    .game_over   (game_over)
  );

  typedef struct { bit done; int lat; } resp_t;
  typedef struct { logic [5:0] sq; logic [3:0] pc; } wr_t;

  resp_t       exp_resp[$];
  wr_t         exp_wr[$];
  logic [13:0] exp_md[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int md_run   = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin : monitor
    resp_t r;
    wr_t   w;
    cyc++;
    if (move_valid && move_ready) acc_cyc = cyc;
    if (move_done || move_reject) begin
      check("resp_pending", int'(exp_resp.size() > 0), 1);
      if (exp_resp.size() > 0) begin
        r = exp_resp.pop_front();
        check("resp_kind_done", int'(move_done), int'(r.done));
        check("resp_latency", cyc - acc_cyc, r.lat);
      end
    end
    if (moveData[0]) begin
      check("md_pending", int'(exp_md.size() > 0), 1);
      if (exp_md.size() > 0) check("moveData", int'(moveData), int'(exp_md[0]));
      md_run++;
    end else if (md_run != 0) begin
      check("chk_req_len", md_run, 4);
      md_run = 0;
      if (exp_md.size() > 0) void'(exp_md.pop_front());
    end
    if (changePiece[10]) begin
      check("wr_pending", int'(exp_wr.size() > 0), 1);
      if (exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        check("wr_square", int'(changePiece[9:4]), int'(w.sq));
        check("wr_piece", int'(changePiece[3:0]), int'(w.pc));
      end
    end
  end

  function automatic logic [255:0] start_board();
    logic [255:0] b;
    logic [3:0]   back [8] = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    b = '0;
    for (int f = 0; f < 8; f++) begin
      b[4*f +: 4]        = back[f];
      b[4*(8+f) +: 4]    = 4'h1;
      b[4*(48+f) +: 4]   = 4'h9;
      b[4*(56+f) +: 4]   = back[f] | 4'h8;
    end
    return b;
  endfunction

  task automatic set_sq(input int s, input logic [3:0] p);
    board[4*s +: 4] = p;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},  int'(move_ready), 1);
    check({tag, "_md"},     int'(moveData), 0);
    check({tag, "_cp"},     int'(changePiece), 0);
    check({tag, "_done"},   int'(move_done), 0);
    check({tag, "_reject"}, int'(move_reject), 0);
    check({tag, "_count"},  int'(move_count), 0);
    check({tag, "_over"},   int'(game_over), 0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!move_ready && n < 30) begin
      @(posedge clk); #2;
      n++;
    end
    if (!move_ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic issue(input logic [5:0] f, input logic [5:0] t, input logic allow);
    move_from  = f;
    move_to    = t;
    allowMove  = allow;
    move_valid = 1'b1;
    @(posedge clk); #2;
    move_valid = 1'b0;
  endtask

  task automatic do_move(input logic [5:0] f, input logic [5:0] t, input logic allow,
                         input bit done, input int lat, input bit chk,
                         input logic [13:0] md, input logic [3:0] dpc);
    int n = 0;
    resp_t r;
    wr_t   w;
    wait_ready("pre");
    r.done = done; r.lat = lat;
    exp_resp.push_back(r);
    if (chk) exp_md.push_back(md);
    if (done) begin
      w.sq = t; w.pc = dpc; exp_wr.push_back(w);
      w.sq = f; w.pc = 4'h0; exp_wr.push_back(w);
    end
    issue(f, t, allow);
    while (exp_resp.size() != 0 && n < 30) begin
      @(posedge clk); #2;
      n++;
    end
    if (exp_resp.size() != 0) begin
      check("resp_timeout", 0, 1);
      exp_resp.delete();
    end
    if (done) begin
      set_sq(t, dpc);
      set_sq(f, 4'h0);
    end
  endtask

  typedef struct { logic [5:0] f; logic [5:0] t; logic [3:0] pc; logic [13:0] md; } shuttle_t;
  shuttle_t shuttle [4] = '{
    '{6'd1,  6'd18, 4'h2, 14'h00A5},
    '{6'd57, 6'd42, 4'hA, 14'h3CD5},
    '{6'd18, 6'd1,  4'h2, 14'h0903},
    '{6'd42, 6'd57, 4'hA, 14'h3573}
  };

  initial begin
    wr_t w;
    int  n;
    reset      = 1'b0;
    board      = start_board();
    move_valid = 1'b0;
    move_from  = '0;
    move_to    = '0;
    allowMove  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("rst");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #2;
    check_reset_vals("idle");

    // white asks to move a black pawn: pre-check reject, no check request
    do_move(6'd52, 6'd44, 1'b1, 1'b0, 1, 1'b0, 14'h0, 4'h0);
    // e2-e4
    do_move(6'd12, 6'd28, 1'b1, 1'b1, 7, 1'b1, 14'h0639, 4'h1);
    wait_ready("t1");
    check("t1_turn", int'(moveData[13]), 1);
    check("t1_count", int'(move_count), 1);

    // black e7-e5 refused by checkAllow
    do_move(6'd52, 6'd36, 1'b0, 1'b0, 5, 1'b1, 14'h3A49, 4'h0);
    // pre-check boundaries under black: same square, empty source, wrong colour, own piece on dst
    do_move(6'd52, 6'd52, 1'b1, 1'b0, 1, 1'b0, 14'h0, 4'h0);
    do_move(6'd40, 6'd32, 1'b1, 1'b0, 1, 1'b0, 14'h0, 4'h0);
    do_move(6'd8,  6'd16, 1'b1, 1'b0, 1, 1'b0, 14'h0, 4'h0);
    do_move(6'd57, 6'd51, 1'b1, 1'b0, 1, 1'b0, 14'h0, 4'h0);
    wait_ready("t3");
    check("t3_turn", int'(moveData[13]), 1);
    check("t3_count", int'(move_count), 1);

    // promotions: black pawn 11->3 (captures queen), white pawn 52->60
    set_sq(11, 4'h9);
    do_move(6'd11, 6'd3, 1'b1, 1'b1, 7, 1'b1, 14'h2587, 4'hD);
    set_sq(52, 4'h1);
    set_sq(60, 4'h0);
    do_move(6'd52, 6'd60, 1'b1, 1'b1, 7, 1'b1, 14'h1A79, 4'h5);
    wait_ready("t4");
    check("t4_count", int'(move_count), 3);
    check("t4_turn", int'(moveData[13]), 1);

    // black queen captures white king
    set_sq(12, 4'hD);
    do_move(6'd12, 6'd4, 1'b1, 1'b1, 7, 1'b1, 14'h2609, 4'hD);
    @(posedge clk); #2;
    check("t5_over", int'(game_over), 1);
    check("t5_count", int'(move_count), 4);
    check("t5_turn", int'(moveData[13]), 0);
    move_from = 6'd1; move_to = 6'd18; allowMove = 1'b1; move_valid = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("t5_ready_low", int'(move_ready), 0);
    check("t5_count_hold", int'(move_count), 4);
    check("t5_over_hold", int'(game_over), 1);
    move_valid = 1'b0;

    // reset out of OVER, then reset again in the middle of WR_DST
    reset = 1'b0;
    #1;
    check_reset_vals("rst_over");
    board = start_board();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #2;
    exp_md.push_back(14'h00A5);
    w.sq = 6'd18; w.pc = 4'h2; exp_wr.push_back(w);
    issue(6'd1, 6'd18, 1'b1);
    n = 0;
    while (!changePiece[10] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_wr_dst", int'(changePiece[10]), 1);
    #1 reset = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #2;
    check_reset_vals("after_mid");

    // 1024 commits wrap the counter
    for (int i = 0; i < 1024; i++) begin
      do_move(shuttle[i%4].f, shuttle[i%4].t, 1'b1, 1'b1, 7, 1'b1, shuttle[i%4].md, shuttle[i%4].pc);
      if (i == 1022) check("wrap_1023", int'(move_count), 1023);
    end
    wait_ready("wrap");
    check("wrap_count", int'(move_count), 0);
    check("wrap_turn", int'(moveData[13]), 0);

    repeat (3) @(posedge clk);
    #2;
    check("q_resp_empty", exp_resp.size(), 0);
    check("q_md_empty", exp_md.size(), 0);
    check("q_wr_empty", exp_wr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
